// File: rtl/ram_ctrl_pkg.sv
// Shared constants and encodings for the two-requester RAM access controller.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_WORDS  = 2 ** DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin select; on a tie the side not granted last wins.
module rr_arbiter2
  import ram_ctrl_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  grant_t last_grant,
  output logic   gnt_a,
  output logic   gnt_b
);

  assign gnt_a = req_a && (!req_b || (last_grant == REQ_B));
  assign gnt_b = req_b && !gnt_a;

endmodule

// File: rtl/ram_access_ctrl.sv
// Arbitrates two masters onto the bit-cell RAM array and sequences one
// fixed-length access per grant.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrate and latch the winning command
// GRANT  | strobes driven, one cycle of setup for the cell muxes
// ACCESS | strobes held; write captured / read sampled at the closing edge
// ACK    | strobes released, one-cycle ack to the winner
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  localparam int WORDS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [WORDS-1:0]  mem_cs,
  output logic              mem_w,
  output logic              mem_r,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  function automatic logic [WORDS-1:0] onehot(input logic [ADDR_W-1:0] a);
    onehot    = '0;
    onehot[a] = 1'b1;
  endfunction

  state_t state;
  grant_t last_grant;
  grant_t winner;
  logic   cmd_we;
  logic   gnt_a, gnt_b;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b)
  );

  assign sel_we    = gnt_b ? we_b    : we_a;
  assign sel_addr  = gnt_b ? addr_b  : addr_a;
  assign sel_wdata = gnt_b ? wdata_b : wdata_a;

  // mem_cs/mem_din double as the latched address and write data of the command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ_B;
      winner     <= REQ_A;
      cmd_we     <= 1'b0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      mem_cs     <= '0;
      mem_w      <= 1'b0;
      mem_r      <= 1'b0;
      mem_din    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_a || gnt_b) begin
            winner  <= gnt_b ? REQ_B : REQ_A;
            cmd_we  <= sel_we;
            mem_cs  <= onehot(sel_addr);
            mem_w   <= sel_we;
            mem_r   <= !sel_we;
            mem_din <= sel_wdata;
            busy    <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: state <= ACCESS;
        ACCESS: begin
          if (!cmd_we) rdata <= mem_dout;
          mem_cs     <= '0;
          mem_w      <= 1'b0;
          mem_r      <= 1'b0;
          mem_din    <= '0;
          busy       <= 1'b0;
          ack_a      <= (winner == REQ_A);
          ack_b      <= (winner == REQ_B);
          last_grant <= winner;
          state      <= ACK;
        end
        ACK: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
